dense_mac_layer1_8: RTL and testbench
=====================================

Name: dense_mac_layer1_8

Overview:
- Fully connected compute stage directly downstream of the layer-1 weight loader (1152 inputs, 8 neurons, int8).
- Consumes the loader's flat weight vector and its done level, plus a flat int8 activation vector.
- Produces 8 signed dot-product results: one MAC lane per neuron, one input index per cycle.
- Registered results and a done level go to the next layer / activation stage.

Parameters:
- IN_SIZE, 1152, number of input activations per neuron
- OUT_SIZE, 8, number of neurons; one MAC lane each
- W, 8, signed weight/activation width
- ACC_W, 32, signed accumulator/result width; must be ≥ 2*W + clog2(IN_SIZE)
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE, weight count
- IDX_W, 11, index counter width; must satisfy 2^IDX_W > IN_SIZE

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; tie to loader done
- weights  in  TOTAL_WEIGHTS*W  flat signed weights
  - weight (o,i) at bits [(o*IN_SIZE+i)*W +: W], neuron-major, matching BRAM load order
- act_in  in  IN_SIZE*W  flat signed activations; act i at [i*W +: W]
- result  out  OUT_SIZE*ACC_W  neuron o at [o*ACC_W +: ACC_W], signed
- busy  out  1  high while in RUN
- done  out  1  high while in DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, idx=0, all accumulators=0, result=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge: clear all accumulators, idx←0, go to RUN.
- RUN (one edge per index):
  - Each edge, every lane o computes acc[o] ← acc[o] + sext(w(o,idx)) * sext(act_in[idx]).
  - Products are 2W-bit signed, sign-extended to ACC_W; all lanes update in parallel.
  - If idx==IN_SIZE-1: perform the final MAC, result[o] ← final sum (acc + product), go to DONE.
  - Otherwise idx←idx+1.
- DONE:
  - result and done are held.
  - Return to IDLE when start=0.
  - While start stays 1, remain in DONE; no restart, so a loader done that stays high triggers exactly one computation.
- Latency:
  - start sampled at edge E0 → MACs at edges E1..E_IN_SIZE → done=1 and result valid after edge E_IN_SIZE.
  - Default: 1152 cycles after E0.
- busy=1 exactly while state==RUN.
- Inputs: weights and act_in must be stable from E0 through the done edge; the block does not latch them.
- start deasserted during RUN: ignored; the computation completes.
- Overflow: none with the defaults (max |sum| < 2^27); wrap-around (two's complement) if ACC_W is undersized.
- Reset mid-RUN: immediate abort; all outputs return to reset values; the next start begins a fresh computation.
- result keeps the previous value until the next DONE entry. It is not cleared on IDLE or RUN entry, only by reset.

Optional Feature:
- Macro: DENSE_RELU_EN
- Defined: on DONE entry, result[o] ← (sum<0) ? 0 : sum. Accumulators themselves are unaffected.
- Undefined: result[o] ← raw signed sum.

Test Plan:
- Reset then start=1; all weights=1, all acts=1 → done after exactly 1152 cycles, every result lane=1152, busy high 1152 cycles.
- Weights (o,i)=o−3 and acts=2 (no ReLU) → result[o]=2304*(o−3), so lane0=−6912 and lane7=9216.
  - With DENSE_RELU_EN: lanes 0–2=0, lane3=0, lanes 4–7 positive values unchanged.
- All weights=−128, all acts=−128 → every lane=18874368, no overflow at ACC_W=32.
  - All weights=−128, acts=127 → every lane=−18726912.
- start held high 3000 cycles → exactly one RUN, done stays 1.
  - start→0 then →1 with new acts → a second computation, previous result held until its done.
- rst_n pulsed low at cycle 500 of RUN → outputs 0 immediately, state IDLE.
  - With start still 1 after release → fresh run; done 1152 cycles later with correct sums.
- Single nonzero pair: w(5,1151)=7, act[1151]=−3, all else 0 → lane5=−21, other lanes 0 (checks final-index MAC is included).

Source files
------------

// File: rtl/dense_mac_layer1_8.sv
// Layer-1 dense stage: one MAC lane per neuron, one input index per cycle.
// Optional macro DENSE_RELU_EN clamps negative sums to zero in the registered result.
module dense_mac_layer1_8 #(
  parameter int IN_SIZE       = 1152,
  parameter int OUT_SIZE      = 8,
  parameter int W             = 8,
  parameter int ACC_W         = 32,
  parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
  parameter int IDX_W         = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [TOTAL_WEIGHTS*W-1:0]  weights,
  input  logic [IN_SIZE*W-1:0]        act_in,
  output logic [OUT_SIZE*ACC_W-1:0]   result,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q [OUT_SIZE];
  logic signed [ACC_W-1:0]   acc_d [OUT_SIZE];
  logic [OUT_SIZE*ACC_W-1:0] result_q, result_d;

  logic signed [W-1:0]       act_cur;
  logic signed [W-1:0]       w_cur [OUT_SIZE];
  logic signed [2*W-1:0]     prod  [OUT_SIZE];
  logic signed [ACC_W-1:0]   sum   [OUT_SIZE];
  logic signed [ACC_W-1:0]   res_v [OUT_SIZE];

  // Per-lane datapath: operands for the current index and the running sum including it.
  always_comb begin
    act_cur = $signed(act_in[32'(idx_q)*W +: W]);
    for (int unsigned o = 0; o < OUT_SIZE; o++) begin
      w_cur[o] = $signed(weights[(o*IN_SIZE + 32'(idx_q))*W +: W]);
      prod[o]  = w_cur[o] * act_cur;
      sum[o]   = acc_q[o] + {{(ACC_W-2*W){prod[o][2*W-1]}}, prod[o]};
`ifdef DENSE_RELU_EN
      res_v[o] = sum[o][ACC_W-1] ? '0 : sum[o];
`else
      res_v[o] = sum[o];
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned o = 0; o < OUT_SIZE; o++) acc_d[o] = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum;
        if (idx_q == IDX_W'(IN_SIZE - 1)) begin
          for (int unsigned o = 0; o < OUT_SIZE; o++) result_d[o*ACC_W +: ACC_W] = res_v[o];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        // A loader done level that stays high must not retrigger a run.
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      for (int unsigned o = 0; o < OUT_SIZE; o++) acc_q[o] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      for (int unsigned o = 0; o < OUT_SIZE; o++) acc_q[o] <= acc_d[o];
    end
  end

  assign result = result_q;
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_dense_mac_layer1_8.sv
// Scoreboard bench for dense_mac_layer1_8: stimulus pushes expected lane sums,
// a monitor pops and compares them on each rising edge of done.
module tb_dense_mac_layer1_8;
  localparam int IN_SIZE  = 1152;
  localparam int OUT_SIZE = 8;
  localparam int W        = 8;
  localparam int ACC_W    = 32;
  localparam int TOTAL    = IN_SIZE * OUT_SIZE;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic [TOTAL*W-1:0]          weights = '0;
  logic [IN_SIZE*W-1:0]        act_in = '0;
  logic [OUT_SIZE*ACC_W-1:0]   result;
  logic                        busy;
  logic                        done;

  int tests = 0;
  int fails = 0;
  logic [OUT_SIZE*ACC_W-1:0] exp_q [$];
  logic                      stim_done = 1'b0;

  dense_mac_layer1_8 #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W),
                       .TOTAL_WEIGHTS(TOTAL), .IDX_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weights(weights),
    .act_in(act_in), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int lane(input int o);
    logic [ACC_W-1:0] v;
    v = result[o*ACC_W +: ACC_W];
    return int'($signed(v));
  endfunction

  task automatic push_exp(input int l0, l1, l2, l3, l4, l5, l6, l7);
    logic [OUT_SIZE*ACC_W-1:0] e;
    e[0*32 +: 32] = relu(l0); e[1*32 +: 32] = relu(l1);
    e[2*32 +: 32] = relu(l2); e[3*32 +: 32] = relu(l3);
    e[4*32 +: 32] = relu(l4); e[5*32 +: 32] = relu(l5);
    e[6*32 +: 32] = relu(l6); e[7*32 +: 32] = relu(l7);
    exp_q.push_back(e);
  endtask

  task automatic push_all(input int v);
    push_exp(v, v, v, v, v, v, v, v);
  endtask

  task automatic fill_w(input logic [7:0] v);
    for (int i = 0; i < TOTAL; i++) weights[i*W +: W] = v;
  endtask

  task automatic fill_a(input logic [7:0] v);
    for (int i = 0; i < IN_SIZE; i++) act_in[i*W +: W] = v;
  endtask

  // Assumes start is already high; E0 is the next rising edge.
  task automatic measure(output int lat, output int busy_n);
    @(posedge clk); #1;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic run_one(input string name);
    int lat, bn;
    @(negedge clk); start = 1'b1;
    measure(lat, bn);
    chk({name, "_latency"}, lat, 1152);
    chk({name, "_busy_cycles"}, bn, 1152);
  endtask

  task automatic stop_and_idle();
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compares every lane when done rises.
  initial begin
    logic done_prev = 1'b0;
    logic [OUT_SIZE*ACC_W-1:0] e;
    while (!stim_done) begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int o = 0; o < OUT_SIZE; o++)
            chk($sformatf("lane%0d", o), lane(o), int'($signed(e[o*32 +: 32])));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    int lat, bn, dlow, bhigh;
    // Reset state
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    for (int o = 0; o < OUT_SIZE; o++) chk($sformatf("reset_lane%0d", o), lane(o), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // All ones
    fill_w(8'd1); fill_a(8'd1);
    push_all(1152);
    run_one("ones");
    stop_and_idle();

    // Weights o-3, acts 2
    for (int o = 0; o < OUT_SIZE; o++)
      for (int i = 0; i < IN_SIZE; i++) weights[(o*IN_SIZE+i)*W +: W] = 8'(o - 3);
    fill_a(8'd2);
    push_exp(-6912, -4608, -2304, 0, 2304, 4608, 6912, 9216);
    run_one("ramp");
    stop_and_idle();

    // Extremes
    fill_w(8'h80); fill_a(8'h80);
    push_all(18874368);
    run_one("neg_neg");
    stop_and_idle();

    fill_a(8'd127);
    push_all(-18726912);
    run_one("neg_pos");

    // start held: no second run, done stays up
    dlow = 0; bhigh = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!done) dlow++;
      if (busy) bhigh++;
    end
    chk("held_done_low_cycles", dlow, 0);
    chk("held_busy_cycles", bhigh, 0);

    // Restart with new acts; old result held until new done
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    fill_a(8'd1);
    push_all(-147456);
    start = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    chk("held_prev_lane0", lane(0), relu(-18726912));
    chk("held_prev_lane7", lane(7), relu(-18726912));
    lat = 0;
    while (!done && lat < 2000) begin @(posedge clk); #1; lat++; end
    chk("restart_done_seen", int'(done), 1);
    stop_and_idle();

    // Reset mid-run, start stays high across release
    fill_w(8'd1); fill_a(8'd1);
    @(negedge clk); start = 1'b1;
    repeat (500) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_lane0", lane(0), 0);
    chk("abort_lane5", lane(5), 0);
    push_all(1152);
    @(negedge clk); rst_n = 1'b1;
    measure(lat, bn);
    chk("rerun_latency", lat, 1152);
    chk("rerun_busy_cycles", bn, 1152);
    stop_and_idle();

    // Single nonzero pair at the final index
    fill_w(8'd0); fill_a(8'd0);
    weights[(5*IN_SIZE+1151)*W +: W] = 8'd7;
    act_in[1151*W +: W] = 8'hFD;
    push_exp(0, 0, 0, 0, 0, -21, 0, 0);
    run_one("last_idx");
    stop_and_idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    stim_done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
